// File: rtl/bfm_adder.sv
// bfm_adder: registered WIDTH-bit adder used as the DUT endpoint of the add
// bench. Each rising clock edge adds A_s and B_s. The sum is wrapped or
// clamped depending on SATURATE, and it is registered together with the
// carry-out. The block also keeps a count of additions and a running
// checksum of every result it has produced.
//
// Ports:
//   clk_i    - clock; all state updates on its rising edge
//   reset_i  - asynchronous active-low reset; clears all state at once
//   A_s, B_s - unsigned operands, sampled on every rising edge
//   res_o    - registered sum (wrapped or saturated)
//   carry_o  - registered carry-out of the unclamped sum
//   cnt_o    - number of additions since reset, wraps at 2^CNT_W
//   acc_o    - sum of all res_o values since reset, modulo 2^ACC_W
module bfm_adder #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 32,
  parameter int ACC_W    = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [ACC_W-1:0] acc_o
);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] res_d, res_q;
  logic             carry_d, carry_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [ACC_W-1:0] acc_d, acc_q;

  // Extend by one bit so the carry-out lands in sum_w[WIDTH].
  assign sum_w   = {1'b0, A_s} + {1'b0, B_s};
  assign carry_d = sum_w[WIDTH];

  generate
    if (SATURATE) begin : g_sat
      assign res_d = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
    end else begin : g_wrap
      assign res_d = sum_w[WIDTH-1:0];
    end
  endgenerate

  assign cnt_d = cnt_q + CNT_W'(1);
  // The checksum adds the value that res_q takes on this edge, not the old
  // res_q. This keeps acc_o equal to the sum of every result shown so far.
  assign acc_d = acc_q + ACC_W'(res_d);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign res_o   = res_q;
  assign carry_o = carry_q;
  assign cnt_o   = cnt_q;
  assign acc_o   = acc_q;

endmodule

// File: tb/tb_bfm_adder.sv
// Directed bench for bfm_adder. It runs a wrap instance (u_wrap) and a
// saturating instance (u_sat) side by side on the same operands.
module tb_bfm_adder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [7:0]  A_s = 8'h00;
  logic [7:0]  B_s = 8'h00;

  logic [7:0]  res_w, res_s;
  logic        carry_w, carry_s;
  logic [31:0] cnt_w, cnt_s;
  logic [15:0] acc_w, acc_s;

  int n_cmp = 0;
  int n_bad = 0;

  bfm_adder #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(32), .ACC_W(16)) u_wrap (
    .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s),
    .res_o(res_w), .carry_o(carry_w), .cnt_o(cnt_w), .acc_o(acc_w)
  );

  bfm_adder #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(32), .ACC_W(16)) u_sat (
    .clk_i(clk_i), .reset_i(reset_i), .A_s(A_s), .B_s(B_s),
    .res_o(res_s), .carry_o(carry_s), .cnt_o(cnt_s), .acc_o(acc_s)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".res"},    64'(res_w),   64'h0);
    chk({tag, ".carry"},  64'(carry_w), 64'h0);
    chk({tag, ".cnt"},    64'(cnt_w),   64'h0);
    chk({tag, ".acc"},    64'(acc_w),   64'h0);
    chk({tag, ".sres"},   64'(res_s),   64'h0);
    chk({tag, ".scnt"},   64'(cnt_s),   64'h0);
    chk({tag, ".sacc"},   64'(acc_s),   64'h0);
  endtask

  // Drive the operands and advance one edge. The task returns 1 ns after
  // the edge, which is where the outputs are sampled.
  task automatic step(input logic [7:0] a, input logic [7:0] b);
    A_s = a;
    B_s = b;
    @(posedge clk_i);
    #1;
  endtask

  // Streaming payload bytes, defined by the bench.
  function automatic logic [7:0] pbyte(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  initial begin
    logic [7:0]  e_res;
    logic [15:0] e_acc;

    // Reset is held while the operands toggle; every output must stay 0.
    for (int i = 0; i < 3; i++) begin
      step((i % 2) ? 8'h34 : 8'h12, (i % 2) ? 8'h12 : 8'h34);
      chk_zero("hold_rst");
    end

    // Release reset; the next edge performs the first addition.
    reset_i = 1'b1;
    step(8'h05, 8'h03);
    chk("add.res", 64'(res_w), 64'h08);
    chk("add.carry", 64'(carry_w), 64'h0);
    chk("add.cnt", 64'(cnt_w), 64'd1);
    chk("add.acc", 64'(acc_w), 64'h0008);
    chk("add.sres", 64'(res_s), 64'h08);

    step(8'hF0, 8'h20);
    chk("wrap1.res", 64'(res_w), 64'h10);
    chk("wrap1.carry", 64'(carry_w), 64'h1);
    chk("wrap1.cnt", 64'(cnt_w), 64'd2);
    chk("wrap1.acc", 64'(acc_w), 64'h0018);
    chk("sat1.res", 64'(res_s), 64'hFF);
    chk("sat1.carry", 64'(carry_s), 64'h1);
    chk("sat1.acc", 64'(acc_s), 64'h0107);

    step(8'hFF, 8'h01);
    chk("wrap2.res", 64'(res_w), 64'h00);
    chk("wrap2.carry", 64'(carry_w), 64'h1);
    chk("wrap2.acc", 64'(acc_w), 64'h0018);
    chk("sat2.res", 64'(res_s), 64'hFF);
    chk("sat2.acc", 64'(acc_s), 64'h0206);

    step(8'h7F, 8'h80);
    chk("nocarry.res", 64'(res_w), 64'hFF);
    chk("nocarry.carry", 64'(carry_w), 64'h0);
    chk("sat3.res", 64'(res_s), 64'hFF);
    chk("sat3.carry", 64'(carry_s), 64'h0);
    chk("sat3.acc", 64'(acc_s), 64'h0305);
    chk("nocarry.cnt", 64'(cnt_w), 64'd4);
    chk("nocarry.acc", 64'(acc_w), 64'h0117);

    // Assert reset between edges; the clear must not wait for the clock.
    #1 reset_i = 1'b0;
    #1 chk_zero("async_rst");
    #3 reset_i = 1'b1;

    // Stream 100 byte pairs and compare each result one cycle later.
    e_acc = '0;
    for (int k = 0; k < 100; k++) begin
      step(pbyte(2 * k), pbyte(2 * k + 1));
      e_res = pbyte(2 * k) + pbyte(2 * k + 1);
      e_acc = e_acc + 16'(e_res);
      chk("stream.res", 64'(res_w), 64'(e_res));
    end
    chk("stream.cnt", 64'(cnt_w), 64'd100);
    chk("stream.acc", 64'(acc_w), 64'(e_acc));

    // Mid-stream reset after 10 additions: a 3 ns low pulse between edges.
    #1 reset_i = 1'b0;
    #2 reset_i = 1'b1;
    for (int k = 0; k < 10; k++) step(pbyte(k), pbyte(k + 50));
    chk("mid.cnt10", 64'(cnt_w), 64'd10);
    #1 reset_i = 1'b0;
    #1 chk_zero("mid_rst");
    #2 reset_i = 1'b1;
    step(8'h21, 8'h43);
    chk("mid.res", 64'(res_w), 64'h64);
    chk("mid.cnt", 64'(cnt_w), 64'd1);
    chk("mid.acc", 64'(acc_w), 64'h0064);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bfm_adder.md
Name: bfm_adder

Overview:
- Registered byte adder used as the DUT endpoint of the DPI-driven add bench.
- Each clock it samples two operands, A_s and B_s, and registers their modulo-2^WIDTH sum on res_o, optionally saturating.
- It also exposes a carry flag, a count of additions performed and a running checksum of results for bench-side cross-checking.

Parameters:
- WIDTH, 8, operand and result width in bits.
- SATURATE, 0, 0 means wrap-around sum; 1 means clamp the sum to 2^WIDTH-1 on overflow.
- CNT_W, 32, width of the addition counter.
- ACC_W, 16, width of the running checksum accumulator.

Ports:
- clk_i, input, 1, sole clock; all state updates on its rising edge.
- reset_i, input, 1, asynchronous active-low reset. Low means reset is asserted; asserting it clears all state immediately, and release is sampled on clk_i.
- A_s, input, WIDTH, operand A, sampled every rising edge.
- B_s, input, WIDTH, operand B, sampled every rising edge.
- res_o, output, WIDTH, registered sum of A_s and B_s.
- carry_o, output, 1, registered carry-out of the unclamped sum.
- cnt_o, output, CNT_W, number of additions registered since reset.
- acc_o, output, ACC_W, running sum of every registered res_o value, modulo 2^ACC_W.

Behaviour:
- Reset values: while reset_i=0, res_o=0, carry_o=0, cnt_o=0 and acc_o=0, regardless of the clock. These values take effect asynchronously on the falling edge of reset_i.
- Reset release: the first rising clk_i edge with reset_i=1 performs the first addition.
- Datapath: the full sum is computed as s = A_s + B_s in WIDTH+1 bits.
  - carry_o <= s[WIDTH].
  - SATURATE=0: res_o <= s[WIDTH-1:0].
  - SATURATE=1: res_o <= all-ones if s[WIDTH]=1, else s[WIDTH-1:0].
- Latency: exactly one cycle. Operands present at edge N appear on res_o and carry_o after edge N, and stay stable until edge N+1.
- No handshake: the block adds every cycle out of reset. Inputs are unsigned, and X inputs are not checked.
- Counter: cnt_o increments by 1 on every non-reset edge and wraps from 2^CNT_W-1 to 0.
- Checksum: acc_o <= acc_o + zero-extended new res_o value, with wrap-around modulo 2^ACC_W.
  - The added value is the same one being written to res_o on that edge.
  - acc_o therefore equals the sum of all res_o values produced so far.
- Reset mid-operation: an assertion mid-stream clears all outputs at once. No partial result is kept, and counting restarts at 0 after release.
- Output res_o is combinationally independent of the current inputs (fully registered); there is no input-to-output combinational path.

Test Plan:
- Reset: hold reset_i=0 while A_s=0x12 and B_s=0x34 toggle with the clock -> res_o, carry_o, cnt_o and acc_o all stay 0. Asserting reset_i=0 asynchronously between edges clears the outputs at once.
- Basic add: release reset, then apply A_s=0x05, B_s=0x03 at edge 1 -> res_o=0x08, carry_o=0, cnt_o=1, acc_o=0x0008 after edge 1.
- Wrap (SATURATE=0): apply A_s=0xF0, B_s=0x20 -> res_o=0x10, carry_o=1. Then A_s=0xFF, B_s=0x01 -> res_o=0x00, carry_o=1.
- Saturate (SATURATE=1): apply A_s=0xF0, B_s=0x20 -> res_o=0xFF, carry_o=1. Then A_s=0x7F, B_s=0x80 -> res_o=0xFF, carry_o=0.
- Streaming: feed 100 consecutive byte pairs (payload bytes 2k and 2k+1 for k=0..99), one pair per cycle.
  - res_o must match (byte[2k]+byte[2k+1]) mod 256 one cycle later for every k.
  - After the stream, cnt_o=100 and acc_o equals the sum of all 100 results mod 65536.
- Mid-stream reset: after 10 additions, pulse reset_i low for 3 ns between edges -> all outputs read 0 immediately. After release, the next addition gives cnt_o=1 and acc_o=res_o.
